// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner. Each digit slot is DIV cycles:
// BLANK cycles dark, then the snapshotted pattern driven onto the shared bus.
module seg_scan_driver #(
    parameter int DIV        = 16,
    parameter int BLANK      = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [7:0] disp_0_i,
    input  logic [7:0] disp_1_i,
    input  logic [7:0] disp_2_i,
    input  logic [7:0] disp_3_i,
    input  logic [7:0] disp_4_i,
    input  logic [7:0] disp_5_i,
    input  logic [7:0] disp_6_i,
    input  logic [7:0] disp_7_i,
    input  logic       page_i,
    output logic [7:0] seg_out_o,
    output logic [7:0] dig_en_o,
    output logic       page_q_o,
    output logic       frame_tick_o
);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    // XOR mask: off level and polarity inversion are the same constant
    localparam logic [7:0]  OFF        = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);

    state_t          state_q;
    logic [15:0]     cnt_q;
    logic [2:0]      idx_q;
    logic [7:0][7:0] snap_q;
    logic            pg_q;
    logic [7:0]      seg_q;
    logic [7:0]      dig_q;
    logic            tick_q;

    logic [7:0][7:0] disp_d;
    logic [15:0]     cnt_d;
    logic [7:0]      onehot_d;

    assign disp_d   = {disp_7_i, disp_6_i, disp_5_i, disp_4_i,
                       disp_3_i, disp_2_i, disp_1_i, disp_0_i};
    assign cnt_d    = cnt_q + 16'd1;
    assign onehot_d = 8'(8'd1 << idx_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            pg_q    <= 1'b0;
            seg_q   <= OFF;
            dig_q   <= OFF;
            tick_q  <= 1'b0;
        end else if (!enable_i) begin
            // snapshot and page are kept; only the scan position is cleared
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= OFF;
            dig_q   <= OFF;
            tick_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_BLANK;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    snap_q  <= disp_d;
                    pg_q    <= page_i;
                    seg_q   <= OFF;
                    dig_q   <= OFF;
                    tick_q  <= 1'b1;
                end
                S_BLANK: begin
                    tick_q <= 1'b0;
                    cnt_q  <= cnt_d;
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= S_DRIVE;
                        seg_q   <= snap_q[idx_q] ^ OFF;
                        dig_q   <= onehot_d ^ OFF;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q <= S_BLANK;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                        seg_q   <= OFF;
                        dig_q   <= OFF;
                        // leaving digit 7 starts a new frame with fresh data
                        if (idx_q == 3'd7) begin
                            snap_q <= disp_d;
                            pg_q   <= page_i;
                            tick_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    seg_q   <= OFF;
                    dig_q   <= OFF;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seg_out_o    = seg_q;
    assign dig_en_o     = dig_q;
    assign page_q_o     = pg_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (active-high DIV=4/BLANK=1 and
// active-low DIV=5/BLANK=2) checked every cycle against a frame-time model.
module tb_seg_scan_driver;

    localparam int DIV_A = 4;
    localparam int BL_A  = 1;
    localparam int DIV_B = 5;
    localparam int BL_B  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] disp [8];
    logic       page;

    logic [7:0] seg_a, dig_a, seg_b, dig_b;
    logic       pq_a, tk_a, pq_b, tk_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    seg_scan_driver #(.DIV(DIV_A), .BLANK(BL_A), .ACTIVE_LOW(1'b0)) dut_a (
        .clock_i(clock), .reset_i(reset), .enable_i(enable),
        .disp_0_i(disp[0]), .disp_1_i(disp[1]), .disp_2_i(disp[2]), .disp_3_i(disp[3]),
        .disp_4_i(disp[4]), .disp_5_i(disp[5]), .disp_6_i(disp[6]), .disp_7_i(disp[7]),
        .page_i(page), .seg_out_o(seg_a), .dig_en_o(dig_a),
        .page_q_o(pq_a), .frame_tick_o(tk_a));

    seg_scan_driver #(.DIV(DIV_B), .BLANK(BL_B), .ACTIVE_LOW(1'b1)) dut_b (
        .clock_i(clock), .reset_i(reset), .enable_i(enable),
        .disp_0_i(disp[0]), .disp_1_i(disp[1]), .disp_2_i(disp[2]), .disp_3_i(disp[3]),
        .disp_4_i(disp[4]), .disp_5_i(disp[5]), .disp_6_i(disp[6]), .disp_7_i(disp[7]),
        .page_i(page), .seg_out_o(seg_b), .dig_en_o(dig_b),
        .page_q_o(pq_b), .frame_tick_o(tk_b));

    // Model: position within the frame t in 0..8*DIV-1; digit = t/DIV, slot offset = t%DIV
    bit         run_m  [2];
    int         t_m    [2];
    logic [7:0] snap_m [2][8];
    logic       pg_m   [2];

    function automatic int div_of(input int m);
        return (m == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int blk_of(input int m);
        return (m == 0) ? BL_A : BL_B;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                run_m[m] = 1'b0;
                t_m[m]   = 0;
                pg_m[m]  = 1'b0;
                for (int k = 0; k < 8; k++) snap_m[m][k] = 8'h00;
            end else if (!enable) begin
                run_m[m] = 1'b0;
            end else begin
                if (run_m[m]) t_m[m] = (t_m[m] + 1) % (8 * div_of(m));
                else          t_m[m] = 0;
                if (!run_m[m] || t_m[m] == 0) begin
                    for (int k = 0; k < 8; k++) snap_m[m][k] = disp[k];
                    pg_m[m] = page;
                end
                run_m[m] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %02h want %02h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            logic [7:0] es, ed, inv;
            logic       et;
            int         d, p;
            inv = (m == 0) ? 8'h00 : 8'hFF;
            es = 8'h00; ed = 8'h00; et = 1'b0;
            if (run_m[m]) begin
                d  = t_m[m] / div_of(m);
                p  = t_m[m] % div_of(m);
                et = (t_m[m] == 0);
                if (p >= blk_of(m)) begin
                    es = snap_m[m][d];
                    ed = 8'(8'd1 << d);
                end
            end
            if (m == 0) begin
                chk("model seg A", seg_a, es ^ inv);
                chk("model dig A", dig_a, ed ^ inv);
                chk("model tick A", {7'd0, tk_a}, {7'd0, et});
                chk("model page A", {7'd0, pq_a}, {7'd0, pg_m[m]});
                chk("onehot A", {7'd0, $onehot0(dig_a)}, 8'd1);
            end else begin
                chk("model seg B", seg_b, es ^ inv);
                chk("model dig B", dig_b, ed ^ inv);
                chk("model tick B", {7'd0, tk_b}, {7'd0, et});
                chk("model page B", {7'd0, pq_b}, {7'd0, pg_m[m]});
                chk("onehot B", {7'd0, $onehot0(~dig_b)}, 8'd1);
            end
        end
    endtask

    // One clock: model follows the edge, DUTs are compared on the falling edge
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_model();
    endtask

    // kind 0: dig_a == v, 1: tk_a high, 2: dig_b == v
    task automatic wait_for(input int kind, input logic [7:0] v, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 120 && !hit; i++) begin
            hit = (kind == 0) ? (dig_a == v) : (kind == 1) ? (tk_a == 1'b1) : (dig_b == v);
            if (!hit) step();
        end
        hit = (kind == 0) ? (dig_a == v) : (kind == 1) ? (tk_a == 1'b1) : (dig_b == v);
        chk(nm, {7'd0, hit}, 8'd1);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] seg;
        logic [7:0] dig;
        logic       tick;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h10, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h10, 8'h01, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h10, 8'h01, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h11, 8'h02, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h11, 8'h02, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h11, 8'h02, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h12, 8'h04, 1'b0};

        for (int m = 0; m < 2; m++) begin
            run_m[m] = 1'b0; t_m[m] = 0; pg_m[m] = 1'b0;
            for (int k = 0; k < 8; k++) snap_m[m][k] = 8'h00;
        end
        reset = 1'b1; enable = 1'b1; page = 1'b0;
        for (int k = 0; k < 8; k++) disp[k] = 8'(8'h10 + k);

        // Reset, start latency and first digits of the basic scan
        for (int i = 0; i < 12; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            step();
            chk($sformatf("vec%0d seg", i), seg_a, vecs[i].seg);
            chk($sformatf("vec%0d dig", i), dig_a, vecs[i].dig);
            chk($sformatf("vec%0d tick", i), {7'd0, tk_a}, {7'd0, vecs[i].tick});
            if (vecs[i].rst) begin
                chk("reset page A", {7'd0, pq_a}, 8'd0);
                chk("reset seg B", seg_b, 8'hFF);
                chk("reset dig B", dig_b, 8'hFF);
            end
        end

        // Tear-free snapshot
        wait_for(1, 8'h00, "wait frame2 tick");
        wait_for(0, 8'h02, "wait digit1");
        disp[3] = 8'hAA; page = 1'b1;
        wait_for(0, 8'h08, "wait digit3 old");
        chk("tear digit3 old", seg_a, 8'h13);
        chk("tear page old", {7'd0, pq_a}, 8'd0);
        wait_for(1, 8'h00, "wait frame3 tick");
        chk("tear page new", {7'd0, pq_a}, 8'd1);
        wait_for(0, 8'h08, "wait digit3 new");
        chk("tear digit3 new", seg_a, 8'hAA);

        // Enable drop during digit 4, then re-enable
        disp[2] = 8'hFC;
        wait_for(0, 8'h10, "wait digit4");
        enable = 1'b0;
        step();
        chk("drop dig", dig_a, 8'h00);
        chk("drop seg", seg_a, 8'h00);
        step(); step(); step();
        enable = 1'b1;
        step();
        chk("reen tick", {7'd0, tk_a}, 8'd1);
        chk("reen dig off", dig_a, 8'h00);
        step();
        chk("reen dig0", dig_a, 8'h01);
        chk("reen seg0", seg_a, 8'h10);

        // Active-low digit 2 drive
        wait_for(2, 8'hFB, "wait B digit2");
        chk("actlow seg2", seg_b, 8'h03);

        // Mid-frame reset during digit 5
        wait_for(0, 8'h20, "wait digit5");
        reset = 1'b1;
        step();
        chk("mrst dig", dig_a, 8'h00);
        chk("mrst seg", seg_a, 8'h00);
        chk("mrst tick", {7'd0, tk_a}, 8'd0);
        chk("mrst seg B", seg_b, 8'hFF);
        chk("mrst dig B", dig_b, 8'hFF);
        reset = 1'b0;
        step();
        chk("mrst restart tick", {7'd0, tk_a}, 8'd1);
        step();
        chk("mrst restart dig0", dig_a, 8'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0) disp[$urandom_range(0, 7)] = 8'($urandom);
            if ($urandom_range(0, 15) == 0) page = ~page;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment scanner. It sits at the board end of the display path and consumes the eight per-register segment patterns and the page selecter produced by the display decode logic. It drives them onto one shared segment bus, enabling one digit at a time with a blanking gap between digits to prevent ghosting. All eight patterns and the page bit are snapshotted at each frame start, so a frame never mixes old and new data.

## Interface
- DIV, 16: clock cycles per digit slot; legal range 2..65535.
- BLANK, 1: cycles at the start of each slot with all digits off; legal range 1..DIV-1.
- ACTIVE_LOW, 0: 1 inverts seg_out and dig_en (lit segment / enabled digit = 0).
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low forces IDLE.
- disp_0 .. disp_7  in  8 each  segment pattern per digit; bit7 = seg a … bit1 = seg g, bit0 = dp; 1 = lit.
- page  in  1  page selecter from the decode logic.
- seg_out  out  8  shared segment bus, with polarity set by ACTIVE_LOW.
- dig_en  out  8  one-hot digit enable; bit k selects digit k.
- page_q  out  1  page value latched at the last frame start.
- frame_tick  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- Registers:
  - state ∈ {IDLE, BLANK, DRIVE}
  - cnt (16 b, counts 0..DIV-1 within a slot)
  - idx (3 b)
  - snap[0..7] (8 b each)
  - page_q
- All outputs are registered and updated on the same edge as state, so the outputs in a cycle reflect the state held in that cycle.
- "Off" level: seg_out = 0x00 and dig_en = 0x00, or 0xFF / 0xFF when ACTIVE_LOW=1.
- IDLE: outputs off, frame_tick = 0. If enable is sampled high, the next state is BLANK with:
  - idx←0, cnt←0
  - snap[k]←disp_k, page_q←page
  - frame_tick←1
- BLANK: outputs off; cnt increments. At cnt == BLANK-1, go to DRIVE.
- DRIVE:
  - dig_en = one-hot(idx), seg_out = snap[idx], with polarity per ACTIVE_LOW.
  - cnt increments.
  - At cnt == DIV-1: cnt←0, idx←idx+1 (7 wraps to 0), state←BLANK.
  - On the wrap 7→0, reload snap and page_q and pulse frame_tick.
- frame_tick is high only in the first BLANK cycle of digit 0.
- enable sampled low in BLANK or DRIVE: the next state is IDLE with outputs off, idx←0, cnt←0. snap and page_q hold their values.
- disp_* and page changes mid-frame have no effect until the next frame start.
- Reset, including mid-frame, overrides everything:
  - state IDLE, cnt 0, idx 0
  - snap all 0x00, page_q 0
  - seg_out/dig_en at the off level, frame_tick 0

## Timing
- Reset values: seg_out off, dig_en off, page_q 0, frame_tick 0.
- Start latency: enable is sampled high at edge N. Cycle N+1 is the first BLANK cycle (frame_tick=1). The first lit cycle is N+1+BLANK.
- Per slot: BLANK cycles off, then DIV-BLANK cycles lit. Frame period = 8·DIV cycles; frame_tick period = 8·DIV.
- dig_en is never multi-hot. Any two consecutive lit digits are separated by ≥1 off cycle.
- Stop latency: enable low sampled at edge M → outputs are off from cycle M+1.
- Re-enable after IDLE always restarts at digit 0 with a fresh snapshot.

## Test plan
- Reset: assert reset 2 cycles with enable=1 → seg_out=0x00, dig_en=0x00, frame_tick=0, page_q=0 for the entire reset period and the first cycle after release.
- Basic scan (DIV=4, BLANK=1): set disp_k=0x10+k and enable=1 → frame_tick=1 in cycle 1, then:
  - cycles 2-4: dig_en=0x01, seg_out=0x10
  - cycle 5: off
  - cycles 6-8: dig_en=0x02, seg_out=0x11 … through digit 7 = 0x17
  - frame_tick repeats every 32 cycles.
- Tear-free snapshot: during digit 1, change disp_3 to 0xAA and toggle page 0→1 → digit 3 still shows 0x13 and page_q stays 0. The next frame shows 0xAA with page_q=1.
- Enable drop: deassert enable during the DRIVE cycles of digit 4 → dig_en=0x00 on the next cycle. Re-enable → frame_tick, then digit 0 lit after BLANK cycles.
- ACTIVE_LOW=1: reset gives seg_out=0xFF, dig_en=0xFF. The digit 2 drive shows dig_en=0xFB, seg_out=~disp_2 (disp_2=0xFC → 0x03).
- Mid-frame reset: assert reset during DRIVE of digit 5 → outputs off next cycle. Release with enable=1 → the scan restarts at digit 0 with frame_tick=1.
